// File: rtl/proc_prog_sequencer_if.sv
// proc_prog_sequencer_if: program-load, control and core-side signals of the program sequencer
interface proc_prog_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W+1:0] load_data;
  logic              start;
  logic              loop_mode;
  logic              abort;
  logic              done;
  logic [DATA_W-1:0] din;
  logic              run;
  logic              busy;
  logic              finished;
  logic              wdog_err;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  instr_cnt;
  logic [CNT_W-1:0]  cycle_cnt;
  modport slave (
    input  load_en, load_addr, load_data, start, loop_mode, abort, done,
    output din, run, busy, finished, wdog_err, pc, instr_cnt, cycle_cnt
  );
  modport master (
    output load_en, load_addr, load_data, start, loop_mode, abort, done,
    input  din, run, busy, finished, wdog_err, pc, instr_cnt, cycle_cnt
  );
endinterface

// File: rtl/proc_prog_sequencer.sv
// proc_prog_sequencer: streams a stored program into the multicycle core with run/done handshaking
module proc_prog_sequencer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WDOG_W = 6,
  parameter int CNT_W  = 16
) (
  input logic clock,
  input logic reset,
  proc_prog_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_IMM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ADV   = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
  logic [DATA_W+1:0] r_mem [DEPTH];
  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_din;
  logic [WDOG_W-1:0] r_wdog;
  logic [WDOG_W-1:0] w_wdog_inc;
  logic [CNT_W-1:0]  r_instr;
  logic [CNT_W-1:0]  r_cycles;
  logic              r_loop;
  logic              r_wdog_err;
  logic [DATA_W+1:0] w_entry;
  logic              w_last;
  logic              w_imm;
  logic              w_active;
  logic              w_end;
  logic              w_abort;
  logic              w_busy;
  logic              w_timeout;
  logic              w_drive;
  assign w_entry    = r_mem[r_pc];
  assign w_last     = w_entry[DATA_W+1];
  assign w_imm      = w_entry[DATA_W];
  assign w_active   = r_state == S_ISSUE || r_state == S_IMM || r_state == S_WAIT || r_state == S_ADV;
  assign w_end      = r_state == S_ADV && w_last && !r_loop;
  assign w_abort    = bus.abort && r_state != S_IDLE;
  assign w_busy     = w_active && !w_end && !bus.abort;
  assign w_wdog_inc = r_wdog + WDOG_W'(1);
  assign w_timeout  = w_wdog_inc == '1;
  assign w_drive    = r_state == S_ISSUE || r_state == S_IMM;
  // program memory: writable only while idle, contents survive reset
  always_ff @(posedge clock) begin
    if (bus.load_en && r_state == S_IDLE) r_mem[bus.load_addr] <= bus.load_data;
  end
  // next-state selection; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = w_imm ? S_IMM : S_WAIT;
      S_IMM:   w_next = S_WAIT;
      S_WAIT:  w_next = bus.done ? S_ADV : w_timeout ? S_ERROR : S_WAIT;
      S_ADV:   w_next = w_end ? S_IDLE : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end
  // state, pc, held din word, watchdog and saturating counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_din      <= '0;
      r_wdog     <= '0;
      r_instr    <= '0;
      r_cycles   <= '0;
      r_loop     <= 1'b0;
      r_wdog_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_drive) r_din <= w_entry[DATA_W-1:0];
      if (r_state == S_ISSUE) r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= w_wdog_inc;
      if (r_state == S_IDLE && bus.start) begin
        r_pc       <= '0;
        r_instr    <= '0;
        r_cycles   <= '0;
        r_wdog_err <= 1'b0;
        r_loop     <= bus.loop_mode;
      end else if (!w_abort) begin
        if (r_state == S_ISSUE && w_imm) r_pc <= r_pc + ADDR_W'(1);
        if (r_state == S_ADV && !w_end) r_pc <= w_last ? '0 : r_pc + ADDR_W'(1);
        if (r_state == S_WAIT && bus.done && r_instr != '1) r_instr <= r_instr + CNT_W'(1);
        if (r_state == S_WAIT && !bus.done && w_timeout) r_wdog_err <= 1'b1;
        if (w_busy && r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
      end
    end
  end
  assign bus.din       = w_drive ? w_entry[DATA_W-1:0] : r_din;
  assign bus.run       = r_state == S_ISSUE && !bus.abort;
  assign bus.busy      = w_busy;
  assign bus.finished  = w_end && !bus.abort;
  assign bus.wdog_err  = r_wdog_err;
  assign bus.pc        = r_pc;
  assign bus.instr_cnt = r_instr;
  assign bus.cycle_cnt = r_cycles;
endmodule

// File: tb/tb_proc_prog_sequencer.sv
// tb_proc_prog_sequencer: directed scenarios against a core model that answers done 3 cycles after run
module tb_proc_prog_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int cd = 0;
  int n_runs = 0;
  int n_fin = 0;
  bit core_en = 1'b1;
  logic [4:0] run_pcs [64];
  proc_prog_sequencer_if bif();
  proc_prog_sequencer dut (.clock(clk), .reset(rst), .bus(bif.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
    bif.done = 1'b0;
    if (cd != 0) begin
      cd--;
      if (cd == 0) bif.done = 1'b1;
    end
    if (core_en && bif.run === 1'b1) cd = 3;
    if (bif.run === 1'b1) begin
      if (n_runs < 64) run_pcs[n_runs] = bif.pc;
      n_runs++;
    end
    if (bif.finished === 1'b1) n_fin++;
  endtask
  task automatic clr();
    n_runs = 0;
    n_fin = 0;
  endtask
  task automatic load(input int a, input logic [17:0] d);
    bif.load_en = 1'b1;
    bif.load_addr = 5'(a);
    bif.load_data = d;
    tick();
    bif.load_en = 1'b0;
  endtask
  task automatic start_prog(input logic lm);
    bif.start = 1'b1;
    bif.loop_mode = lm;
    tick();
    bif.start = 1'b0;
  endtask
  task automatic wait_finish(input string name);
    int k = 0;
    while (n_fin == 0 && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (n_fin == 0) begin errors++; $display("FAIL %s finish timeout: no finished pulse within %0d cycles", name, k); end
    tick();
  endtask
  task automatic load_main();
    load(0, {2'b01, 16'h1000});
    load(1, {2'b00, 16'h0003});
    load(2, {2'b10, 16'h2000});
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bif.busy); end
    checks++; if (bif.din !== 16'h0 || bif.run !== 1'b0) begin errors++; $display("FAIL reset din/run: got %h/%b want 0000/0", bif.din, bif.run); end
    checks++; if (bif.pc !== 5'd0 || bif.instr_cnt !== 16'd0 || bif.cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset pc/counters: got %0d/%0d/%0d want 0/0/0", bif.pc, bif.instr_cnt, bif.cycle_cnt); end
    checks++; if (bif.wdog_err !== 1'b0 || bif.finished !== 1'b0) begin errors++; $display("FAIL reset flags: got wdog=%b fin=%b want 0/0", bif.wdog_err, bif.finished); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_basic();
    load_main();
    clr();
    start_prog(1'b0);
    checks++; if (bif.run !== 1'b1 || bif.din !== 16'h1000) begin errors++; $display("FAIL basic issue: got run=%b din=%h want 1/1000", bif.run, bif.din); end
    tick();
    checks++; if (bif.din !== 16'h0003 || bif.pc !== 5'd1 || bif.run !== 1'b0) begin errors++; $display("FAIL basic imm: got din=%h pc=%0d run=%b want 0003/1/0", bif.din, bif.pc, bif.run); end
    tick();
    checks++; if (bif.din !== 16'h0003) begin errors++; $display("FAIL basic imm hold: got %h want 0003", bif.din); end
    wait_finish("basic");
    checks++; if (bif.instr_cnt !== 16'd2 || bif.pc !== 5'd2) begin errors++; $display("FAIL basic counts: got instr=%0d pc=%0d want 2/2", bif.instr_cnt, bif.pc); end
    checks++; if (bif.cycle_cnt !== 16'd9) begin errors++; $display("FAIL basic cycles: got %0d want 9", bif.cycle_cnt); end
    checks++; if (n_runs != 2 || run_pcs[0] !== 5'd0 || run_pcs[1] !== 5'd2) begin errors++; $display("FAIL basic runs: got n=%0d pcs=%0d,%0d want 2 at 0,2", n_runs, run_pcs[0], run_pcs[1]); end
    checks++; if (n_fin != 1 || bif.busy !== 1'b0) begin errors++; $display("FAIL basic finish: got fin=%0d busy=%b want 1/0", n_fin, bif.busy); end
  endtask
  task automatic test_loop_abort();
    int k = 0;
    clr();
    start_prog(1'b1);
    while (bif.instr_cnt !== 16'd3 && k < 200) begin
      tick();
      k++;
    end
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    cd = 0;
    tick();
    checks++; if (bif.instr_cnt !== 16'd3 || bif.busy !== 1'b0) begin errors++; $display("FAIL loop abort: got instr=%0d busy=%b want 3/0", bif.instr_cnt, bif.busy); end
    checks++; if (bif.cycle_cnt !== 16'd14) begin errors++; $display("FAIL loop cycles: got %0d want 14", bif.cycle_cnt); end
    checks++; if (n_fin != 0 || n_runs != 3 || run_pcs[2] !== 5'd0) begin errors++; $display("FAIL loop runs: got fin=%0d runs=%0d third=%0d want 0/3/0", n_fin, n_runs, run_pcs[2]); end
  endtask
  task automatic test_watchdog();
    clr();
    core_en = 1'b0;
    start_prog(1'b0);
    repeat (64) tick();
    checks++; if (bif.busy !== 1'b1 || bif.wdog_err !== 1'b0) begin errors++; $display("FAIL wdog early: got busy=%b err=%b want 1/0", bif.busy, bif.wdog_err); end
    tick();
    checks++; if (bif.wdog_err !== 1'b1 || bif.busy !== 1'b0) begin errors++; $display("FAIL wdog trip: got err=%b busy=%b want 1/0", bif.wdog_err, bif.busy); end
    checks++; if (bif.cycle_cnt !== 16'd65 || bif.instr_cnt !== 16'd0) begin errors++; $display("FAIL wdog counts: got cyc=%0d instr=%0d want 65/0", bif.cycle_cnt, bif.instr_cnt); end
    tick();
    checks++; if (bif.wdog_err !== 1'b1 || bif.busy !== 1'b0) begin errors++; $display("FAIL wdog sticky: got err=%b busy=%b want 1/0", bif.wdog_err, bif.busy); end
    core_en = 1'b1;
    start_prog(1'b0);
    checks++; if (bif.wdog_err !== 1'b0 || bif.run !== 1'b1) begin errors++; $display("FAIL wdog clear: got err=%b run=%b want 0/1", bif.wdog_err, bif.run); end
    wait_finish("wdog restart");
  endtask
  task automatic test_load_busy();
    clr();
    start_prog(1'b0);
    bif.load_en = 1'b1;
    bif.load_addr = 5'd0;
    bif.load_data = 18'h0FFFF;
    repeat (3) tick();
    bif.load_en = 1'b0;
    wait_finish("load busy");
    clr();
    start_prog(1'b0);
    checks++; if (bif.din !== 16'h1000) begin errors++; $display("FAIL load busy word: got %h want 1000", bif.din); end
    tick();
    checks++; if (bif.pc !== 5'd1 || bif.din !== 16'h0003) begin errors++; $display("FAIL load busy flags: got pc=%0d din=%h want 1/0003", bif.pc, bif.din); end
    wait_finish("load busy rerun");
  endtask
  task automatic test_reset_mid();
    clr();
    start_prog(1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bif.busy !== 1'b0 || bif.run !== 1'b0 || bif.din !== 16'h0 || bif.pc !== 5'd0) begin errors++; $display("FAIL midreset outs: got busy=%b run=%b din=%h pc=%0d want 0/0/0000/0", bif.busy, bif.run, bif.din, bif.pc); end
    checks++; if (bif.instr_cnt !== 16'd0 || bif.cycle_cnt !== 16'd0) begin errors++; $display("FAIL midreset counters: got %0d/%0d want 0/0", bif.instr_cnt, bif.cycle_cnt); end
    rst = 1'b0;
    clr();
    start_prog(1'b0);
    wait_finish("midreset rerun");
    checks++; if (bif.instr_cnt !== 16'd2 || bif.pc !== 5'd2 || bif.cycle_cnt !== 16'd9) begin errors++; $display("FAIL midreset rerun: got instr=%0d pc=%0d cyc=%0d want 2/2/9", bif.instr_cnt, bif.pc, bif.cycle_cnt); end
  endtask
  task automatic test_wrap();
    int k = 0;
    for (int i = 0; i < 32; i++) load(i, {2'b00, 16'h0100 + 16'(i)});
    clr();
    start_prog(1'b0);
    while (n_runs < 33 && k < 400) begin
      tick();
      k++;
    end
    checks++; if (n_runs != 33 || run_pcs[31] !== 5'd31 || run_pcs[32] !== 5'd0) begin errors++; $display("FAIL wrap pc: got runs=%0d pcs=%0d,%0d want 33 at 31,0", n_runs, run_pcs[31], run_pcs[32]); end
    checks++; if (bif.din !== 16'h0100) begin errors++; $display("FAIL wrap din: got %h want 0100", bif.din); end
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    cd = 0;
    tick();
    checks++; if (bif.busy !== 1'b0 || n_fin != 0) begin errors++; $display("FAIL wrap abort: got busy=%b fin=%0d want 0/0", bif.busy, n_fin); end
    checks++; if (bif.instr_cnt !== 16'd32 || bif.cycle_cnt !== 16'd160) begin errors++; $display("FAIL wrap counts: got instr=%0d cyc=%0d want 32/160", bif.instr_cnt, bif.cycle_cnt); end
  endtask
  initial begin
    bif.load_en = 1'b0;
    bif.load_addr = '0;
    bif.load_data = '0;
    bif.start = 1'b0;
    bif.loop_mode = 1'b0;
    bif.abort = 1'b0;
    bif.done = 1'b0;
    test_reset();
    test_basic();
    test_loop_abort();
    test_watchdog();
    test_load_busy();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/proc_prog_sequencer.md
Name: proc_prog_sequencer

Overview:
- Synthesizable program feeder for the multicycle processor core.
- Holds a DEPTH-entry program memory, loaded through a write port.
- On start, streams instruction and immediate words onto the core's din, pulses run, waits for done, and counts instructions and cycles.
- Has a per-instruction watchdog, an optional loop mode, and abort. It replaces hand-timed stimulus of din/run.

Parameters:
DATA_W, 16, width of din and of each program word
DEPTH, 32, program memory entries (power of two)
ADDR_W, 5, log2(DEPTH)
WDOG_W, 6, watchdog counter width; timeout after 2^WDOG_W-1 cycles without done
CNT_W, 16, width of the instruction and cycle counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
load_en  in  1  write program entry this cycle (ignored unless idle)
load_addr  in  ADDR_W  program write address
load_data  in  DATA_W+2  {last, imm_follows, word}
start  in  1  begin execution at address 0
loop_mode  in  1  sampled at start; wrap to address 0 after the last entry
abort  in  1  stop execution, return to IDLE
done  in  1  core instruction-complete strobe
din  out  DATA_W  word driven to core
run  out  1  one-cycle instruction-issue pulse to core
busy  out  1  high from start until FINISH/ERROR/abort
finished  out  1  one-cycle pulse when the last entry completes (non-loop)
wdog_err  out  1  sticky; set on watchdog timeout, cleared by start or reset
pc  out  ADDR_W  address of the current entry
instr_cnt  out  CNT_W  instructions completed since start (saturating)
cycle_cnt  out  CNT_W  cycles while busy (saturating)

Behaviour:
- Reset (synchronous): state IDLE; din=0, run=0, busy=0, finished=0, wdog_err=0, pc=0, instr_cnt=0, cycle_cnt=0. Memory contents are not reset.
- Memory: synchronous write on load_en while in IDLE; load_en is ignored in other states. Reads are combinational from pc.
- States: IDLE, ISSUE, IMM, WAIT, ADV, ERROR.
- IDLE:
  - On start: pc=0, counters=0, wdog_err=0, latch loop_mode, go to ISSUE next cycle.
  - If start and load_en coincide, the write completes and start is honoured.
- ISSUE (1 cycle):
  - din=word[pc], run=1, watchdog cleared.
  - If imm_follows, go to IMM. Else go to WAIT.
- IMM: pc=pc+1; din=word[pc+1], held; run=0; go to WAIT in the same transition.
- WAIT:
  - din holds its value, run=0, watchdog increments each cycle.
  - On done: instr_cnt+1, go to ADV.
  - On watchdog reaching all-ones without done: wdog_err=1, go to ERROR.
  - If done and timeout coincide, done wins.
- ADV (1 cycle):
  - If last of the current entry and not loop: finished=1 for that cycle, busy=0, go to IDLE.
  - If last and loop: pc=0, go to ISSUE.
  - Else: pc+1, go to ISSUE.
  - pc at DEPTH-1 without last wraps to 0.
- ERROR: busy=0, run=0; go to IDLE on the next cycle. wdog_err stays set.
- abort: from any non-IDLE state, go to IDLE next cycle; busy=0, run=0, finished=0, counters hold their values. abort takes priority over done.
- busy is 1 in ISSUE, IMM, WAIT and ADV (except the finishing ADV cycle).
- cycle_cnt increments every cycle busy=1. Both counters saturate at all-ones.
- start while busy is ignored.
- A done strobe outside WAIT is ignored.
- Reset mid-run returns to the reset values immediately; the program memory is preserved.

Test Plan:
- Load entries 0:{0,1,mvi R0} 1:{0,0,#3} 2:{1,0,add R0,R0}; start; model core asserting done 3 cycles after run → run pulses at ISSUE of entries 0 and 2 only; din=0x0003 during entry 1; finished pulse; instr_cnt=2, pc=2.
- Same program with loop_mode=1; abort after 3 completed instructions → instr_cnt=3, busy=0, no finished pulse, pc=0 region re-entered once.
- done never asserted → wdog_err=1 after 63 WAIT cycles, busy falls, state IDLE; next start clears wdog_err.
- load_en while busy with addr 0, data 0xFFFF → memory unchanged; readback after finish shows original word.
- Reset asserted in WAIT → all outputs return to reset values next edge; restart runs the same program correctly.
- 32-entry program without any last flag, loop_mode=0 → pc wraps 31→0, cycle_cnt keeps counting, abort terminates cleanly.
